// File: rtl/iot_sensor_pkg.sv
// Shared types for the sensor-node power management blocks.
//   pwr_mode_t        : operating mode as seen by host and register block
//   pwr_gate_state_t  : sequencing state of pwr_gate_ctrl
//   is_deep_mode()    : true for modes that are entered via channel drain
package iot_sensor_pkg;

  typedef enum logic [1:0] {
    PWR_NORMAL = 2'd0,
    PWR_LOW    = 2'd1,
    PWR_SLEEP  = 2'd2,
    PWR_DEEP   = 2'd3
  } pwr_mode_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_LOWPWR,
    ST_WAKE
  } pwr_gate_state_t;

  function automatic logic is_deep_mode(input pwr_mode_t m);
    return (m == PWR_SLEEP) || (m == PWR_DEEP);
  endfunction

endpackage

// File: rtl/pwr_idle_timer.sv
// Per-channel idle counter for LOW-mode gating.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   active_i       : channel activity; clears the count
//   limit_i        : idle cycles tolerated before the channel may be gated
//   under_limit_o  : registered count is still below limit_i
// The count saturates at all-ones so a long-idle channel never wraps back
// into the "recently active" range.
module pwr_idle_timer #(
  parameter int unsigned IDLE_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              active_i,
  input  logic [IDLE_W-1:0] limit_i,
  output logic              under_limit_o
);

  logic [IDLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (active_i)          cnt_d = '0;
    else if (cnt_q != '1)  cnt_d = cnt_q + IDLE_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign under_limit_o = (cnt_q < limit_i);

endmodule

// File: rtl/pwr_gate_ctrl.sv
// System power / clock-gating controller for NUM_CH gated channels.
//   clk, rst               : clock, synchronous active-high reset
//   mode_req_valid/_ready  : mode request handshake; mode_req is pwr_mode_t
//   cur_mode               : currently applied mode
//   ch_active              : per-channel activity
//   ch_always_on           : channels never gated
//   ch_wake_en             : channels whose activity wakes SLEEP/DEEP
//   idle_limit             : LOW-mode idle cycles before gating
//   sleep_period           : SLEEP sample-pulse period (0 = no pulses)
//   ch_clk_en, sys_clk_en  : registered clock enables
//   wake_event             : pulse on activity-triggered wake
//   drain_timeout          : pulse when drain was forced after DRAIN_MAX
//   busy                   : high in DRAIN or WAKE
module pwr_gate_ctrl
  import iot_sensor_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned IDLE_W    = 8,
  parameter int unsigned TIMER_W   = 16,
  parameter int unsigned DRAIN_MAX = 255,
  parameter int unsigned WAKE_DLY  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_req_valid,
  input  logic [1:0]         mode_req,
  output logic               mode_req_ready,
  output logic [1:0]         cur_mode,
  input  logic [NUM_CH-1:0]  ch_active,
  input  logic [NUM_CH-1:0]  ch_always_on,
  input  logic [NUM_CH-1:0]  ch_wake_en,
  input  logic [IDLE_W-1:0]  idle_limit,
  input  logic [TIMER_W-1:0] sleep_period,
  output logic [NUM_CH-1:0]  ch_clk_en,
  output logic               sys_clk_en,
  output logic               wake_event,
  output logic               drain_timeout,
  output logic               busy
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_MAX + 1);
  localparam int unsigned WAKE_W  = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;

  pwr_gate_state_t    state_q, state_d;
  pwr_mode_t          mode_q, mode_d, target_q, target_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [NUM_CH-1:0]  ch_en_q, ch_en_d, under_limit;
  logic               sys_en_q, sys_en_d;
  logic               wake_ev_q, wake_ev_d, dto_q, dto_d;
  logic               req_fire, wake_hit, in_sleep, sample_pulse;
  pwr_mode_t          req_mode;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_idle
    pwr_idle_timer #(.IDLE_W(IDLE_W)) u_idle (
      .clk_i         (clk),
      .rst_i         (rst),
      .active_i      (ch_active[i]),
      .limit_i       (idle_limit),
      .under_limit_o (under_limit[i])
    );
  end

  assign req_mode       = pwr_mode_t'(mode_req);
  assign mode_req_ready = (state_q == ST_RUN) || (state_q == ST_LOWPWR);
  assign req_fire       = mode_req_valid && mode_req_ready;
  assign wake_hit       = |(ch_active & ch_wake_en);
  assign in_sleep       = (state_q == ST_LOWPWR) && (mode_q == PWR_SLEEP);
  assign sample_pulse   = in_sleep && (sleep_period != '0) &&
                          (timer_q == sleep_period - TIMER_W'(1));

  // Timer is cleared whenever not sleeping, which covers SLEEP entry.
  always_comb begin
    timer_d = '0;
    if (in_sleep) begin
      if (sleep_period == '0) timer_d = timer_q;
      else if (sample_pulse)  timer_d = '0;
      else                    timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    target_d    = target_q;
    drain_cnt_d = '0;
    wake_cnt_d  = '0;
    wake_ev_d   = 1'b0;
    dto_d       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_fire) begin
          if (is_deep_mode(req_mode)) begin
            target_d = req_mode;
            state_d  = ST_DRAIN;
          end else begin
            mode_d = req_mode;
          end
        end
      end
      ST_DRAIN: begin
        // Idle exit is tested first so it wins over a coincident timeout.
        if (ch_active == '0) begin
          state_d = ST_LOWPWR;
          mode_d  = target_q;
        end else if (drain_cnt_q == DRAIN_W'(DRAIN_MAX - 1)) begin
          dto_d   = 1'b1;
          state_d = ST_LOWPWR;
          mode_d  = target_q;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_LOWPWR: begin
        wake_ev_d = wake_hit;
        // A wake-up request sets the target; wake activity otherwise forces
        // a return to NORMAL, overriding a coincident SLEEP/DEEP request.
        if (req_fire && !is_deep_mode(req_mode)) begin
          target_d = req_mode;
          state_d  = ST_WAKE;
        end else if (wake_hit) begin
          target_d = PWR_NORMAL;
          state_d  = ST_WAKE;
        end else if (req_fire) begin
          mode_d = req_mode;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == WAKE_W'(WAKE_DLY - 1)) begin
          state_d = ST_RUN;
          mode_d  = target_q;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ch_en_d  = '1;
    sys_en_d = 1'b1;
    if (mode_req_ready) begin
      case (mode_q)
        PWR_LOW:   ch_en_d = ch_active | under_limit;
        PWR_SLEEP: begin
          ch_en_d  = ch_active | {NUM_CH{sample_pulse}};
          sys_en_d = (|ch_active) || sample_pulse;
        end
        PWR_DEEP: begin
          ch_en_d  = ch_wake_en;
          sys_en_d = 1'b0;
        end
        default: ;
      endcase
    end
    ch_en_d = ch_en_d | ch_always_on;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      mode_q      <= PWR_NORMAL;
      target_q    <= PWR_NORMAL;
      drain_cnt_q <= '0;
      wake_cnt_q  <= '0;
      timer_q     <= '0;
      ch_en_q     <= '1;
      sys_en_q    <= 1'b1;
      wake_ev_q   <= 1'b0;
      dto_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      drain_cnt_q <= drain_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      timer_q     <= timer_d;
      ch_en_q     <= ch_en_d;
      sys_en_q    <= sys_en_d;
      wake_ev_q   <= wake_ev_d;
      dto_q       <= dto_d;
    end
  end

  assign cur_mode      = mode_q;
  assign ch_clk_en     = ch_en_q;
  assign sys_clk_en    = sys_en_q;
  assign wake_event    = wake_ev_q;
  assign drain_timeout = dto_q;
  assign busy          = (state_q == ST_DRAIN) || (state_q == ST_WAKE);

endmodule
